// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: word handshake plus serial output bundle for serial_frame_tx
//   din        parallel word offered by the producer
//   din_valid  din is valid
//   din_ready  transmitter is idle and can take a word
//   sout       serial line, idles high
//   sout_en    one-cycle strobe in the last cycle of each data bit
//   busy       frame in progress
//   done       one-cycle pulse in the last stop-bit cycle
interface serial_frame_tx_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_en;
    logic             busy;
    logic             done;
    modport master (output din, din_valid, input din_ready, sout, sout_en, busy, done);
    modport slave  (input din, din_valid, output din_ready, sout, sout_en, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start bit, data MSB first, optional even parity, stop bit
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    serial_frame_tx_if slave: din/din_valid/din_ready in, sout/sout_en/busy/done out
module serial_frame_tx #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1,
    parameter int BIT_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    serial_frame_tx_if.slave  bus
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             par_q, par_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             sout_q, sout_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             last;
    assign last = cyc_q == CW'(BIT_CYCLES - 1);
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        par_d   = par_q;
        bit_d   = bit_q;
        cyc_d   = (state_q == IDLE || last) ? '0 : cyc_q + 1'b1;
        case (state_q)
            IDLE:   if (bus.din_valid) begin
                        state_d = START;
                        word_d  = bus.din;
                        par_d   = ^bus.din;
                    end
            START:  if (last) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
            DATA:   if (last) begin
                        if (bit_q == BW'(WIDTH - 1))
                            state_d = PARITY_EN ? PARITY : STOP;
                        else
                            bit_d = bit_q + 1'b1;
                    end
            PARITY: if (last) state_d = STOP;
            STOP:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from where the FSM will be next cycle.
        sout_d = state_d == START  ? 1'b0 :
                 state_d == DATA   ? word_d[BW'(WIDTH - 1) - bit_d] :
                 state_d == PARITY ? par_d : 1'b1;
        en_d   = state_d == DATA && cyc_d == CW'(BIT_CYCLES - 1);
        done_d = state_d == STOP && cyc_d == CW'(BIT_CYCLES - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            cyc_q   <= '0;
            sout_q  <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            sout_q  <= sout_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= state_d != IDLE;
        end
    end
    assign bus.din_ready = state_q == IDLE && !reset;
    assign bus.sout      = sout_q;
    assign bus.sout_en   = en_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench over three configurations (parity/no parity/3-cycle bits)
module tb_serial_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [3:0] din [3];
    logic       vld [3];
    logic       rst [3];
    logic       acc [3];
    logic       rdy [3];
    logic       sout [3];
    logic       en [3];
    logic       busy [3];
    logic       done [3];
    logic [2:0] exp_q [3][$];
    logic [3:0] wq [3][$];
    logic [3:0] sh [3];
    int n_cmp = 0;
    int n_bad = 0;
    for (genvar g = 0; g < 3; g++) begin : u
        serial_frame_tx_if #(.WIDTH(4)) bus ();
        assign bus.din       = din[g];
        assign bus.din_valid = vld[g];
        assign rdy[g]        = bus.din_ready;
        assign sout[g]       = bus.sout;
        assign en[g]         = bus.sout_en;
        assign busy[g]       = bus.busy;
        assign done[g]       = bus.done;
        serial_frame_tx #(.WIDTH(4), .PARITY_EN(g != 1), .BIT_CYCLES(g == 2 ? 3 : 1)) dut (
            .clk(clk), .reset(rst[g]), .bus(bus));
    end
    function automatic int pe(int i);
        return i != 1 ? 1 : 0;
    endfunction
    function automatic int bc(int i);
        return i == 2 ? 3 : 1;
    endfunction
    function automatic void chk(string name, int i, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endfunction
    // Reference frame: list of line bits, each expanded to bc() cycles of {sout, sout_en, done}.
    function automatic void expect_frame(int i, logic [3:0] w);
        logic bits [$];
        bits.push_back(1'b0);
        for (int k = 3; k >= 0; k--) bits.push_back(w[k]);
        if (pe(i) != 0) bits.push_back(^w);
        bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++)
            for (int c = 0; c < bc(i); c++)
                exp_q[i].push_back({bits[j], (j >= 1 && j <= 4 && c == bc(i) - 1),
                                    (j == bits.size() - 1 && c == bc(i) - 1)});
        wq[i].push_back(w);
    endfunction
    task automatic tick();
        logic r [3];
        #7;
        for (int i = 0; i < 3; i++) begin
            acc[i] = vld[i] && rdy[i] && !rst[i];
            r[i]   = rst[i];
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            if (r[i]) begin
                exp_q[i].delete();
                wq[i].delete();
            end else if (acc[i]) expect_frame(i, din[i]);
        #1;
    endtask
    task automatic send(int i, logic [3:0] w, bit keep);
        bit got = 1'b0;
        din[i] = w;
        vld[i] = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            tick();
            got = acc[i];
        end
        chk("accept", i, {7'b0, got}, 8'd1);
        if (!keep) begin
            vld[i] = 1'b0;
            din[i] = 4'($urandom);
        end
    endtask
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic       b;
            logic [2:0] e;
            logic [3:0] w;
            b = exp_q[i].size() > 0;
            e = 3'b100;
            if (b) e = exp_q[i].pop_front();
            chk("outputs", i, {3'b0, sout[i], en[i], done[i], busy[i], rdy[i]},
                {3'b0, e, b, !b && !rst[i]});
            if (en[i]) sh[i] = {sh[i][2:0], sout[i]};
            if (done[i]) begin
                w = 4'hx;
                if (wq[i].size() > 0) w = wq[i].pop_front();
                chk("capture", i, {4'b0, sh[i]}, {4'b0, w});
            end
        end
    end
    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; vld[i] = 1'b0; rst[i] = 1'b1; acc[i] = 1'b0; sh[i] = '0;
        end
        @(posedge clk);
        #1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick();
        send(0, 4'b1011, 1'b0);
        send(1, 4'b0110, 1'b0);
        send(2, 4'b1000, 1'b0);
        repeat (25) tick();
        send(0, 4'h5, 1'b1);
        send(0, 4'hA, 1'b0);
        repeat (10) tick();
        send(0, 4'hC, 1'b0);
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        tick();
        send(0, 4'h9, 1'b0);
        repeat (10) tick();
        rst[0] = 1'b1; din[0] = 4'h3; vld[0] = 1'b1;
        tick();
        rst[0] = 1'b0; vld[0] = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 12; k++)
            for (int i = 0; i < 3; i++) begin
                send(i, 4'($urandom), 1'b0);
                repeat ($urandom_range(0, 3)) tick();
            end
        repeat (30) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
